// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one page of CPU memory into PPU OAMDATA.
// Optional build macro OAM_DMA_ODD_ALIGN_EN adds the ALIGN cycle when the HALT cycle has parity 1.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_DATA_REG = 3'h4,
    parameter int          BYTE_COUNT   = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_IN,
    input  logic        CPU_wren,
    output logic        CPU_HALT,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RDEN,
    input  logic [7:0]  MEM_DATA_IN,
    output logic [2:0]  PPU_CPU_ADDR,
    output logic [7:0]  PPU_DATA_OUT,
    output logic        PPU_wren,
    output logic        DMA_BUSY,
    output logic        DMA_DONE,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

    state_t     state_q, state_d;
    logic [7:0] page_q;
    logic [7:0] idx_q;
    logic       done_q;
    logic       trigger;
    logic       last_byte;

    assign trigger   = (state_q == S_IDLE) && CPU_wren && (CPU_ADDR == DMA_REG_ADDR);
    assign last_byte = (idx_q == LAST_IDX);

`ifdef OAM_DMA_ODD_ALIGN_EN
    // Models the CPU get/put cycle; only needed when odd HALT cycles insert ALIGN.
    logic parity_q;

    always_ff @(posedge CLK) begin
        if (Reset) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_WRITE) && last_byte;
            if (trigger) begin
                page_q <= CPU_DATA_IN;
                idx_q  <= 8'h00;
            end else if (state_q == S_WRITE) begin
                // Wrapping to 0 keeps reads inside the page and leaves idx clean for the next run.
                idx_q <= last_byte ? 8'h00 : idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = S_HALT;
`ifdef OAM_DMA_ODD_ALIGN_EN
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
`else
            S_HALT:  state_d = S_READ;
`endif
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = last_byte ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CPU_HALT     = 1'b0;
        DMA_BUSY     = 1'b0;
        MEM_ADDR     = 16'h0000;
        MEM_RDEN     = 1'b0;
        PPU_CPU_ADDR = 3'h0;
        PPU_DATA_OUT = 8'h00;
        PPU_wren     = 1'b0;
        if (state_q != S_IDLE) begin
            CPU_HALT = 1'b1;
            DMA_BUSY = 1'b1;
        end
        if (state_q == S_READ) begin
            MEM_RDEN = 1'b1;
            MEM_ADDR = {page_q, idx_q};
        end
        if (state_q == S_WRITE) begin
            PPU_wren     = 1'b1;
            PPU_CPU_ADDR = OAM_DATA_REG;
            PPU_DATA_OUT = MEM_DATA_IN;
        end
    end

    assign DMA_DONE  = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: walks whole transfers cycle by cycle and checks halt length,
// read addresses, PPU write data via an expected queue, done pulse, aborts and back-to-back starts.
module tb_oam_dma;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_IN;
    logic        CPU_wren;
    logic        CPU_HALT;
    logic [15:0] MEM_ADDR;
    logic        MEM_RDEN;
    logic [7:0]  MEM_DATA_IN;
    logic [2:0]  PPU_CPU_ADDR;
    logic [7:0]  PPU_DATA_OUT;
    logic        PPU_wren;
    logic        DMA_BUSY;
    logic        DMA_DONE;
    logic [2:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       tb_par;

    oam_dma dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_DATA_IN  (CPU_DATA_IN),
        .CPU_wren     (CPU_wren),
        .CPU_HALT     (CPU_HALT),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RDEN     (MEM_RDEN),
        .MEM_DATA_IN  (MEM_DATA_IN),
        .PPU_CPU_ADDR (PPU_CPU_ADDR),
        .PPU_DATA_OUT (PPU_DATA_OUT),
        .PPU_wren     (PPU_wren),
        .DMA_BUSY     (DMA_BUSY),
        .DMA_DONE     (DMA_DONE),
        .dbg_state    (dbg_state)
    );

    // clock / reset-tracking block
    always #5 CLK = ~CLK;

    // Reference get/put parity: cleared by reset, toggles every clock.
    always @(posedge CLK) tb_par <= Reset ? 1'b0 : ~tb_par;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // CPU memory: returns the addressed byte the cycle after a read strobe.
    always @(posedge CLK) begin
        if (Reset)         MEM_DATA_IN <= 8'h00;
        else if (MEM_RDEN) MEM_DATA_IN <= mem_byte(MEM_ADDR);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a $4014 write; want_par selects the HALT-cycle parity (-1 = any).
    task automatic trigger(input logic [7:0] pg, input int want_par);
        if (want_par >= 0)
            while (tb_par == want_par[0]) @(negedge CLK);
        CPU_ADDR    = 16'h4014;
        CPU_DATA_IN = pg;
        CPU_wren    = 1'b1;
        @(negedge CLK);
        CPU_wren    = 1'b0;
        CPU_ADDR    = 16'h0000;
        CPU_DATA_IN = 8'h00;
    endtask

    // Entered at the negedge of the HALT cycle; returns at the negedge of the first IDLE cycle.
    task automatic watch(input logic [7:0] pg, input int inj_at, input int abort_at);
        int halt_len = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        int done_cnt = 0;
        int first_rd = -1;
        int addr_err = 0;
        int data_err = 0;
        int misc_err = 0;
        int exp_len = 513;
        int exp_first = 1;
        logic [15:0] last_rd = 16'h0000;
        logic [7:0]  exp_b;
        string p;
        p = $sformatf("p%02h", pg);
`ifdef OAM_DMA_ODD_ALIGN_EN
        if (tb_par) begin
            exp_len   = 514;
            exp_first = 2;
        end
`endif
        exp_q.delete();
        for (int c = 0; c < 1000; c++) begin
            if (!CPU_HALT) break;
            halt_len++;
            if (DMA_BUSY !== 1'b1) misc_err++;
            if (MEM_RDEN && PPU_wren) misc_err++;
            if (DMA_DONE) done_cnt++;
            if (MEM_RDEN) begin
                if (first_rd < 0) first_rd = c;
                if (MEM_ADDR !== {pg, rd_cnt[7:0]}) addr_err++;
                last_rd = MEM_ADDR;
                exp_q.push_back(mem_byte({pg, rd_cnt[7:0]}));
                rd_cnt++;
            end
            if (PPU_wren) begin
                if (PPU_CPU_ADDR !== 3'h4) misc_err++;
                if (exp_q.size() == 0) data_err++;
                else begin
                    exp_b = exp_q.pop_front();
                    if (PPU_DATA_OUT !== exp_b) data_err++;
                end
                wr_cnt++;
            end
            CPU_wren    = (c == inj_at);
            CPU_ADDR    = (c == inj_at) ? 16'h4014 : 16'h0000;
            CPU_DATA_IN = (c == inj_at) ? 8'h05 : 8'h00;
            if (abort_at >= 0 && wr_cnt == abort_at) begin
                Reset = 1'b1;
                @(negedge CLK);
                Reset = 1'b0;
                check({p, "_abort_halt"}, 32'(CPU_HALT), 0);
                check({p, "_abort_busy"}, 32'(DMA_BUSY), 0);
                check({p, "_abort_done"}, 32'(DMA_DONE), 0);
                check({p, "_abort_addr_err"}, addr_err, 0);
                return;
            end
            @(negedge CLK);
        end
        CPU_wren    = 1'b0;
        CPU_ADDR    = 16'h0000;
        CPU_DATA_IN = 8'h00;
        check({p, "_halt_len"}, halt_len, exp_len);
        check({p, "_first_rd"}, first_rd, exp_first);
        check({p, "_rd_cnt"}, rd_cnt, 256);
        check({p, "_wr_cnt"}, wr_cnt, 256);
        check({p, "_last_rd"}, 32'(last_rd), 32'({pg, 8'hFF}));
        check({p, "_addr_err"}, addr_err, 0);
        check({p, "_data_err"}, data_err, 0);
        check({p, "_misc_err"}, misc_err, 0);
        check({p, "_early_done"}, done_cnt, 0);
        check({p, "_done"}, 32'(DMA_DONE), 1);
        check({p, "_busy_idle"}, 32'(DMA_BUSY), 0);
    endtask

    initial begin
        Reset       = 1'b1;
        CPU_ADDR    = 16'h0000;
        CPU_DATA_IN = 8'h00;
        CPU_wren    = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_halt", 32'(CPU_HALT), 0);
        check("rst_rden", 32'(MEM_RDEN), 0);
        check("rst_wren", 32'(PPU_wren), 0);
        check("rst_busy", 32'(DMA_BUSY), 0);
        check("rst_done", 32'(DMA_DONE), 0);
        check("rst_addr", 32'(MEM_ADDR), 0);
        check("rst_state", 32'(dbg_state), 0);
        Reset = 1'b0;
        @(negedge CLK);

        // Page $02, HALT parity 0
        trigger(8'h02, 0);
        watch(8'h02, -1, -1);
        @(negedge CLK);
        check("p02_done_once", 32'(DMA_DONE), 0);
        check("p02_idle_halt", 32'(CPU_HALT), 0);

        // Page $02, HALT parity 1
        repeat (2) @(negedge CLK);
        trigger(8'h02, 1);
        watch(8'h02, -1, -1);
        @(negedge CLK);

        // Page $FF ends at $FFFF; following run must restart at index 0
        trigger(8'hFF, -1);
        watch(8'hFF, -1, -1);
        @(negedge CLK);
        trigger(8'h10, -1);
        watch(8'h10, -1, -1);
        @(negedge CLK);

        // Trigger during an active transfer is ignored
        trigger(8'h03, -1);
        watch(8'h03, 100, -1);
        @(negedge CLK);
        check("p03_no_retrigger", 32'(CPU_HALT), 0);

        // Reset after byte 100 aborts, then a fresh transfer from $0700
        trigger(8'h04, -1);
        watch(8'h04, -1, 100);
        @(negedge CLK);
        check("abort_still_idle", 32'(CPU_HALT), 0);
        trigger(8'h07, -1);
        watch(8'h07, -1, -1);

        // Back-to-back: trigger in the DMA_DONE cycle
        @(negedge CLK);
        trigger(8'h08, -1);
        watch(8'h08, -1, -1);
        trigger(8'h09, -1);
        watch(8'h09, -1, -1);
        @(negedge CLK);

        // Writes to other registers never start a transfer
        CPU_wren = 1'b1;
        CPU_ADDR = 16'h4015;
        CPU_DATA_IN = 8'h02;
        @(negedge CLK);
        CPU_ADDR = 16'h2004;
        @(negedge CLK);
        CPU_wren = 1'b0;
        CPU_ADDR = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            check("other_reg_halt", 32'(CPU_HALT), 0);
            check("other_reg_rden", 32'(MEM_RDEN), 0);
            @(negedge CLK);
        end
        check("other_reg_state", 32'(dbg_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
